// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the PC redirect unit.
// The FSM state encoding, the fetch stride and the default reset PC live here.
package pc_redirect_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HOLD = 2'b01,
        PEND = 2'b10
    } pc_state_e;

    localparam int PC_INC = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect.sv
// Fetch PC sequencer: redirect, stall hold and pending-redirect handling.
// Optional BRANCH_STATS_EN adds saturating redirect/pend counters.
module pc_redirect
    import pc_redirect_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             BEQ,
    input  logic             BNE,
    input  logic             BLT,
    input  logic             BGE,
    input  logic             jump,
    input  logic [WIDTH-1:0] target,
    input  logic             stall,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             misalign,
    output logic [1:0]       state
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      redirect_cnt,
    output logic [31:0]      pend_cnt
`endif
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             misalign_q, misalign_d;

    logic             take;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] pc_inc;

    assign take   = BEQ | BNE | BLT | BGE | jump;
    assign tgt    = target & ~WIDTH'(1);
    assign pc_inc = pc_q + WIDTH'(PC_INC);

    assign pc       = pc_q;
    assign pc_plus4 = pc_inc;
    assign flush    = take & nReset;
    assign misalign = misalign_q;
    assign state    = state_q;

    // Next PC / state: a redirect wins over stall and over a pending target.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        misalign_d = 1'b0;
        if (take) begin
            misalign_d = tgt[1];
            if (imem_ready) begin
                pc_d    = tgt;
                state_d = RUN;
            end else begin
                pend_pc_d = tgt;
                state_d   = PEND;
            end
        end else begin
            case (state_q)
                HOLD: begin
                    if (!stall) begin
                        state_d = RUN;
                    end
                end
                PEND: begin
                    if (imem_ready) begin
                        pc_d    = pend_pc_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    if (stall && imem_ready) begin
                        state_d = HOLD;
                    end else if (!stall && imem_ready) begin
                        pc_d = pc_inc;
                    end
                end
            endcase
        end
    end

    // PC, pending target, state and misalign pulse registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef BRANCH_STATS_EN
    generate
        logic [31:0] redirect_cnt_q, redirect_cnt_d;
        logic [31:0] pend_cnt_q, pend_cnt_d;

        // Saturating counts of redirects and of cycles spent in PEND.
        always_comb begin
            redirect_cnt_d = redirect_cnt_q;
            pend_cnt_d     = pend_cnt_q;
            if (take && redirect_cnt_q != 32'hFFFF_FFFF) begin
                redirect_cnt_d = redirect_cnt_q + 32'd1;
            end
            if (state_q == PEND && pend_cnt_q != 32'hFFFF_FFFF) begin
                pend_cnt_d = pend_cnt_q + 32'd1;
            end
        end

        // Counter registers.
        always_ff @(posedge clock or negedge nReset) begin
            if (!nReset) begin
                redirect_cnt_q <= '0;
                pend_cnt_q     <= '0;
            end else begin
                redirect_cnt_q <= redirect_cnt_d;
                pend_cnt_q     <= pend_cnt_d;
            end
        end

        assign redirect_cnt = redirect_cnt_q;
        assign pend_cnt     = pend_cnt_q;
    endgenerate
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Scoreboard bench for pc_redirect: driver queues expectations,
// monitor pops and compares flush mid-cycle and pc/state/misalign after the edge.
module tb_pc_redirect;
    import pc_redirect_pkg::*;

    logic        clock;
    logic        nReset;
    logic        BEQ, BNE, BLT, BGE, jump;
    logic [31:0] target;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign;
    logic [1:0]  state;
`ifdef BRANCH_STATS_EN
    logic [31:0] redirect_cnt;
    logic [31:0] pend_cnt;
`endif

    pc_redirect dut (
        .clock       (clock),
        .nReset      (nReset),
        .BEQ         (BEQ),
        .BNE         (BNE),
        .BLT         (BLT),
        .BGE         (BGE),
        .jump        (jump),
        .target      (target),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .flush       (flush),
        .misalign    (misalign),
        .state       (state)
`ifdef BRANCH_STATS_EN
        ,
        .redirect_cnt(redirect_cnt),
        .pend_cnt    (pend_cnt)
`endif
    );

    typedef struct {
        logic        flush;
        logic        now_chk;
        logic [31:0] now_pc;
        logic [31:0] pc;
        logic [1:0]  st;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] T_BEQ = 5'b10000;
    localparam logic [4:0] T_BNE = 5'b01000;
    localparam logic [4:0] T_BLT = 5'b00100;
    localparam logic [4:0] T_BGE = 5'b00010;
    localparam logic [4:0] T_JMP = 5'b00001;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input logic rst, input logic [4:0] br,
                        input logic [31:0] tg, input logic stl,
                        input logic rdy, input logic ef,
                        input logic [31:0] epc, input logic [1:0] est,
                        input logic emis);
        exp_t e;
        @(negedge clock);
        nReset = rst;
        {BEQ, BNE, BLT, BGE, jump} = br;
        target = tg;
        stall = stl;
        imem_ready = rdy;
        e.flush = ef;
        e.now_chk = !rst;
        e.now_pc = 32'h0;
        e.pc = epc;
        e.st = est;
        e.mis = emis;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (flush !== e.flush) begin
                    errors++;
                    $display("FAIL flush t=%0t got=%b exp=%b",
                             $time, flush, e.flush);
                end
                if (e.now_chk) begin
                    checks++;
                    if (pc !== e.now_pc) begin
                        errors++;
                        $display("FAIL reset_pc t=%0t got=%h exp=%h",
                                 $time, pc, e.now_pc);
                    end
                end
                @(posedge clock);
                #1;
                checks++;
                if (pc !== e.pc || pc_plus4 !== e.pc + 32'd4 ||
                    state !== e.st || misalign !== e.mis) begin
                    errors++;
                    $display("FAIL post t=%0t got pc=%h p4=%h st=%b mis=%b exp pc=%h p4=%h st=%b mis=%b",
                             $time, pc, pc_plus4, state, misalign,
                             e.pc, e.pc + 32'd4, e.st, e.mis);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        nReset = 1'b0;
        {BEQ, BNE, BLT, BGE, jump} = NONE;
        target = 32'h0;
        stall = 1'b0;
        imem_ready = 1'b1;

        // reset, then sequential fetch
        step(0, NONE,  32'h0,   0, 1, 0, 32'h0,   RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h4,   RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h8,   RUN,  0);
        // go to 0x100, then BEQ to 0x40
        step(1, T_JMP, 32'h100, 0, 1, 1, 32'h100, RUN,  0);
        step(1, T_BEQ, 32'h40,  0, 1, 1, 32'h40,  RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h44,  RUN,  0);
        // redirect while imem busy
        step(1, T_JMP, 32'h200, 0, 0, 1, 32'h44,  PEND, 0);
        step(1, NONE,  32'h0,   0, 0, 0, 32'h44,  PEND, 0);
        step(1, NONE,  32'h0,   0, 0, 0, 32'h44,  PEND, 0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h200, RUN,  0);
        // newest pending redirect wins
        step(1, T_JMP, 32'h300, 0, 0, 1, 32'h200, PEND, 0);
        step(1, T_BLT, 32'h310, 0, 0, 1, 32'h200, PEND, 0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h310, RUN,  0);
        // stall hold and release without advance
        step(1, NONE,  32'h0,   1, 1, 0, 32'h310, HOLD, 0);
        step(1, NONE,  32'h0,   1, 1, 0, 32'h310, HOLD, 0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h310, RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h314, RUN,  0);
        step(1, NONE,  32'h0,   0, 0, 0, 32'h314, RUN,  0);
        // redirect beats stall, from RUN and from HOLD
        step(1, T_BNE, 32'h80,  1, 1, 1, 32'h80,  RUN,  0);
        step(1, NONE,  32'h0,   1, 1, 0, 32'h80,  HOLD, 0);
        step(1, T_BGE, 32'h90,  1, 1, 1, 32'h90,  RUN,  0);
        // misaligned target
        step(1, T_JMP, 32'h103, 0, 1, 1, 32'h102, RUN,  1);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h106, RUN,  0);
        step(1, T_JMP, 32'h2,   0, 0, 1, 32'h106, PEND, 1);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h2,   RUN,  0);
        // wrap-around
        step(1, T_JMP, 32'hFFFF_FFFC, 0, 1, 1, 32'hFFFF_FFFC, RUN, 0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h0,   RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h4,   RUN,  0);
        // reset while pending, with a take during reset
        step(1, T_JMP, 32'h500, 0, 0, 1, 32'h4,   PEND, 0);
        step(1, NONE,  32'h0,   0, 0, 0, 32'h4,   PEND, 0);
        step(0, T_JMP, 32'h600, 0, 0, 0, 32'h0,   RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h4,   RUN,  0);
        step(1, NONE,  32'h0,   0, 1, 0, 32'h8,   RUN,  0);

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
